ldm_writeback_sequencer: RTL

- Write-side master for the 16-entry register file. Drives its PW/RW/LE write port during ARM load-multiple (LDM, increment-after) instructions.
- Walks a 16-bit register list lowest-index first. For each set bit it fetches one word from data memory over a request/ready handshake, then issues one register-file write.
- Optionally writes the updated base address back to Rn.
- R15 is not writable through the register file, so an R15 load is redirected to a PC-load strobe.

---
 rtl/ldm_writeback_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ldm_writeback_sequencer.sv
// Write-side master for the 16-entry register file during LDM (increment-after):
// fetches one word per listed register, writes it back, optionally updates the base.
module ldm_writeback_sequencer #(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [15:0] REGLIST,
    input  logic [31:0] BASE_ADDR,
    input  logic        WB_EN,
    input  logic [3:0]  RN,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_RDY,
    input  logic [31:0] MEM_DATA,
    output logic [31:0] PW,
    output logic [3:0]  RW,
    output logic        LE,
    output logic        PC_LOAD,
    output logic [31:0] PC_OUT,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned AW    = 32;
    localparam int unsigned NREG  = 16;
    localparam int unsigned IW    = 4;
    localparam logic [IW-1:0] PC_IDX = IW'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_WBASE,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [NREG-1:0] list_q, list_d;
    logic [NREG-1:0] orig_q, orig_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [IW-1:0]   target_q, target_d;
    logic            wb_en_q, wb_en_d;
    logic [IW-1:0]   rn_q, rn_d;

    logic            mem_req_q, mem_req_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [AW-1:0]   pw_q, pw_d;
    logic [IW-1:0]   rw_q, rw_d;
    logic            le_q, le_d;
    logic            pc_load_q, pc_load_d;
    logic [AW-1:0]   pc_out_q, pc_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NREG-1:0] list_after;
    logic [AW-1:0]   addr_inc;
    logic [IW-1:0]   lowest;
    logic            base_wb_ok;

    // Priority pick of the lowest set register index
    function automatic logic [IW-1:0] lowest_set(input logic [NREG-1:0] l);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (l[i]) r = IW'(i);
        end
        return r;
    endfunction

    assign lowest     = lowest_set(list_q);
    assign list_after = list_q & ~(NREG'(1) << target_q);
    assign addr_inc   = addr_q + AW'(ADDR_STEP);
    assign base_wb_ok = wb_en_q && (rn_q != PC_IDX) && !orig_q[rn_q];

    // Next state and next registered outputs, decoded from the state being entered
    always_comb begin
        state_d    = state_q;
        list_d     = list_q;
        orig_d     = orig_q;
        addr_d     = addr_q;
        target_d   = target_q;
        wb_en_d    = wb_en_q;
        rn_d       = rn_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        pw_d       = pw_q;
        rw_d       = rw_q;
        le_d       = 1'b0;
        pc_load_d  = 1'b0;
        pc_out_d   = pc_out_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    list_d  = REGLIST;
                    orig_d  = REGLIST;
                    addr_d  = BASE_ADDR;
                    wb_en_d = WB_EN;
                    rn_d    = RN;
                    if (REGLIST != '0) begin
                        state_d    = S_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = BASE_ADDR;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (MEM_RDY) begin
                    state_d  = S_WRITE;
                    target_d = lowest;
                    if (lowest != PC_IDX) begin
                        le_d = 1'b1;
                        rw_d = lowest;
                        pw_d = MEM_DATA;
                    end else begin
                        pc_load_d = 1'b1;
                        pc_out_d  = MEM_DATA;
                    end
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_q;
                end
            end
            S_WRITE: begin
                list_d = list_after;
                addr_d = addr_inc;
                if (list_after != '0) begin
                    state_d    = S_FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_inc;
                end else if (base_wb_ok) begin
                    state_d = S_WBASE;
                    le_d    = 1'b1;
                    rw_d    = rn_q;
                    pw_d    = addr_inc;
                end else begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end
            end
            S_WBASE: begin
                state_d = S_FIN;
                done_d  = 1'b1;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            list_q     <= '0;
            orig_q     <= '0;
            addr_q     <= '0;
            target_q   <= '0;
            wb_en_q    <= 1'b0;
            rn_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pw_q       <= '0;
            rw_q       <= '0;
            le_q       <= 1'b0;
            pc_load_q  <= 1'b0;
            pc_out_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            orig_q     <= orig_d;
            addr_q     <= addr_d;
            target_q   <= target_d;
            wb_en_q    <= wb_en_d;
            rn_q       <= rn_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pw_q       <= pw_d;
            rw_q       <= rw_d;
            le_q       <= le_d;
            pc_load_q  <= pc_load_d;
            pc_out_q   <= pc_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign MEM_REQ  = mem_req_q;
    assign MEM_ADDR = mem_addr_q;
    assign PW       = pw_q;
    assign RW       = rw_q;
    assign LE       = le_q;
    assign PC_LOAD  = pc_load_q;
    assign PC_OUT   = pc_out_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule
